vga_stream_out: RTL and testbench

Parametrised Avalon-ST-to-VGA output stage that replaces the fixed 640x480 video output of the streaming path. It generates VGA/ADV7123 timing from the system clock via a pixel-enable divider, pulls one RGB pixel per active pixel slot from an upstream Avalon-ST source, and locks frames to start-of-packet. It also provides underflow recovery, a sticky underflow flag and a built-in colour-bar test mode. It sits between the last streaming filter and the board VGA pins.

---
 rtl/vga_stream_out.sv | 185 ++++++++++++++++++
 tb/tb_vga_stream_out.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/vga_stream_out.sv
// Avalon-ST to VGA/ADV7123 output stage: divided pixel timing, start-of-packet frame
// locking with underflow recovery, sticky underflow flag and a colour-bar test mode.
module vga_stream_out #(
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int COLOR_BITS = 8,
  parameter int CLK_DIV    = 2,
  parameter int SYNC_POL   = 0
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [3*COLOR_BITS-1:0]   in_data,
  input  logic                      in_valid,
  input  logic                      in_sop,
  input  logic                      in_eop,
  output logic                      in_ready,
  input  logic                      pattern_en,
  input  logic                      clr_underflow,
  output logic                      underflow,
  output logic                      locked,
  output logic                      vga_clk,
  output logic                      vga_hs,
  output logic                      vga_vs,
  output logic                      vga_blank_n,
  output logic                      vga_sync_n,
  output logic [COLOR_BITS-1:0]     vga_r,
  output logic [COLOR_BITS-1:0]     vga_g,
  output logic [COLOR_BITS-1:0]     vga_b
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL + 1);
  localparam int VW      = $clog2(V_TOTAL + 1);
  localparam int DW      = $clog2(CLK_DIV);
  localparam int PW      = 3 * COLOR_BITS;

  localparam logic [HW-1:0] H_ACT_C  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] H_SS_C   = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] H_SE_C   = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [HW-1:0] H_LAST_C = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT_C  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] V_SS_C   = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] V_SE_C   = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [VW-1:0] V_LAST_C = VW'(V_TOTAL - 1);
  localparam logic [DW-1:0] DIV_LAST_C = DW'(CLK_DIV - 1);
  localparam logic [DW-1:0] DIV_HALF_C = DW'(CLK_DIV / 2);
  localparam logic          SYNC_ON    = (SYNC_POL != 0);

  typedef enum logic [1:0] {SEEK, WAIT_FRAME, LOCKED} state_t;

  state_t           state, state_nxt;
  logic [DW-1:0]    div, div_nxt;
  logic [HW-1:0]    h;
  logic [VW-1:0]    v;
  logic             pix_en, active, frame_start, slot;
  logic             h_sync, v_sync, uf_set;
  logic [PW-1:0]    rgb_p0;
  logic [PW-1:0]    rgb_p1;
  logic             blank_n_p1, hs_p1, vs_p1, vclk_p1, underflow_q;
  logic             unused_eop;

  assign unused_eop = in_eop;

  // Eight equal-width bars: white, yellow, cyan, green, magenta, red, blue, black.
  function automatic logic [PW-1:0] bar_color(input logic [HW-1:0] hpos);
    logic [2:0] idx;
    idx = 3'(({3'b000, hpos} << 3) / (HW+3)'(H_ACTIVE));
    return {{COLOR_BITS{~idx[1]}}, {COLOR_BITS{~idx[2]}}, {COLOR_BITS{~idx[0]}}};
  endfunction

  always_comb begin
    pix_en      = (div == DIV_LAST_C);
    div_nxt     = pix_en ? '0 : div + DW'(1);
    active      = (h < H_ACT_C) && (v < V_ACT_C);
    frame_start = pix_en && (h == '0) && (v == '0);
    slot        = pix_en && active;
    h_sync      = (h >= H_SS_C) && (h < H_SE_C);
    v_sync      = (v >= V_SS_C) && (v < V_SE_C);
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    rgb_p0    = '0;
    uf_set    = 1'b0;
    if (pattern_en) begin
      state_nxt = SEEK;
      if (active) rgb_p0 = bar_color(h);
    end else begin
      unique case (state)
        SEEK: begin
          in_ready = !(in_valid && in_sop);
          if (in_valid && in_sop) state_nxt = WAIT_FRAME;
        end
        WAIT_FRAME: begin
          in_ready = frame_start;
          if (frame_start) begin
            if (in_valid && in_sop) begin
              state_nxt = LOCKED;
              rgb_p0    = in_data;
            end else begin
              state_nxt = SEEK;
            end
          end
        end
        LOCKED: begin
          // An early sop is left waiting on the bus so it can open the next frame.
          in_ready = slot && !(in_valid && in_sop && !frame_start);
          if (slot) begin
            if (!in_valid) begin
              uf_set    = 1'b1;
              state_nxt = SEEK;
            end else if (in_sop && !frame_start) begin
              state_nxt = WAIT_FRAME;
            end else begin
              rgb_p0 = in_data;
              if (frame_start && !in_sop) state_nxt = SEEK;
            end
          end
        end
        default: state_nxt = SEEK;
      endcase
    end
    if (reset) in_ready = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div         <= '0;
      h           <= '0;
      v           <= '0;
      state       <= SEEK;
      underflow_q <= 1'b0;
    end else begin
      div   <= div_nxt;
      state <= state_nxt;
      if (pix_en) begin
        if (h == H_LAST_C) begin
          h <= '0;
          v <= (v == V_LAST_C) ? '0 : v + VW'(1);
        end else begin
          h <= h + HW'(1);
        end
      end
      if (uf_set)             underflow_q <= 1'b1;
      else if (clr_underflow) underflow_q <= 1'b0;
    end
  end

  // Stage p1: pin registers, loaded once per pixel and held for CLK_DIV clocks.
  always_ff @(posedge clk) begin
    if (reset) begin
      rgb_p1     <= '0;
      blank_n_p1 <= 1'b0;
      hs_p1      <= !SYNC_ON;
      vs_p1      <= !SYNC_ON;
      vclk_p1    <= 1'b0;
    end else begin
      vclk_p1 <= (div_nxt >= DIV_HALF_C);
      if (pix_en) begin
        rgb_p1     <= rgb_p0;
        blank_n_p1 <= active;
        hs_p1      <= h_sync ? SYNC_ON : !SYNC_ON;
        vs_p1      <= v_sync ? SYNC_ON : !SYNC_ON;
      end
    end
  end

  assign {vga_r, vga_g, vga_b} = rgb_p1;
  assign vga_blank_n = blank_n_p1;
  assign vga_hs      = hs_p1;
  assign vga_vs      = vs_p1;
  assign vga_clk     = vclk_p1;
  assign vga_sync_n  = 1'b0;
  assign underflow   = underflow_q;
  assign locked      = (state == LOCKED);

endmodule

// File: tb/tb_vga_stream_out.sv
// Directed bench for vga_stream_out with a 14x7 pixel raster (8x4 active), CLK_DIV 2.
module tb_vga_stream_out;

  localparam int MAXK = 512;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [23:0] in_data = '0;
  logic        in_valid = 1'b0, in_sop = 1'b0, in_eop = 1'b0;
  logic        pattern_en = 1'b0, clr_underflow = 1'b0;
  logic        in_ready, underflow, locked, vga_clk, vga_hs, vga_vs, vga_blank_n, vga_sync_n;
  logic [7:0]  vga_r, vga_g, vga_b;

  vga_stream_out #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .COLOR_BITS(8), .CLK_DIV(2), .SYNC_POL(0)
  ) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_sop(in_sop),
    .in_eop(in_eop), .in_ready(in_ready), .pattern_en(pattern_en),
    .clr_underflow(clr_underflow), .underflow(underflow), .locked(locked),
    .vga_clk(vga_clk), .vga_hs(vga_hs), .vga_vs(vga_vs), .vga_blank_n(vga_blank_n),
    .vga_sync_n(vga_sync_n), .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int k;
  bit src_on, jump_en;
  int src_f, src_p, drop_k;

  logic [23:0] o_rgb [MAXK];
  logic o_hs [MAXK], o_vs [MAXK], o_blank [MAXK], o_lock [MAXK], o_uf [MAXK];
  logic o_clk [MAXK], o_rdy [MAXK], o_acc [MAXK];

  function automatic logic [23:0] pix(input int f, input int p);
    return {8'(p), 8'(f), 8'h5A ^ 8'(p)};
  endfunction

  // One clock: record outputs at the falling edge, present the next source beat.
  task automatic step();
    if (k < MAXK) begin
      o_rgb[k] = {vga_r, vga_g, vga_b};
      o_hs[k] = vga_hs; o_vs[k] = vga_vs; o_blank[k] = vga_blank_n;
      o_lock[k] = locked; o_uf[k] = underflow; o_clk[k] = vga_clk;
    end
    if (jump_en && src_f == 0 && src_p == 5) begin
      src_f = 1; src_p = 0;
    end
    in_valid = src_on && (k != drop_k);
    in_data  = pix(src_f, src_p);
    in_sop   = (src_p == 0);
    in_eop   = (src_p == 31);
    #1;
    if (k < MAXK) begin
      o_rdy[k] = in_ready;
      o_acc[k] = in_valid && in_ready;
    end
    if (in_valid && in_ready) begin
      src_p = src_p + 1;
      if (src_p == 32) begin src_p = 0; src_f = src_f + 1; end
    end
    @(negedge clk);
    k = k + 1;
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic restart(input bit pat, input int f, input int p);
    reset = 1'b1; pattern_en = pat; src_f = f; src_p = p; src_on = 1'b1;
    drop_k = -1; jump_en = 1'b0; clr_underflow = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    k = 0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1; in_valid = 1'b1; in_sop = 1'b0; pattern_en = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checks++; if ({vga_r, vga_g, vga_b} !== 24'h0) begin errors++; $display("FAIL rst_rgb: got %h expected 000000", {vga_r, vga_g, vga_b}); end
    checks++; if (vga_blank_n !== 1'b0) begin errors++; $display("FAIL rst_blank: got %b expected 0", vga_blank_n); end
    checks++; if ({vga_hs, vga_vs} !== 2'b11) begin errors++; $display("FAIL rst_sync: got %b expected 11", {vga_hs, vga_vs}); end
    checks++; if (vga_clk !== 1'b0) begin errors++; $display("FAIL rst_vga_clk: got %b expected 0", vga_clk); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_ready: got %b expected 0", in_ready); end
    checks++; if ({locked, underflow, vga_sync_n} !== 3'b000) begin errors++; $display("FAIL rst_flags: got %b expected 000", {locked, underflow, vga_sync_n}); end
  endtask

  task automatic test_timing();
    logic [23:0] bars [8];
    int hs_low, blank_hi, vs_low, rdy_cnt, clk_bad, lock_cnt, fall1, fall2;
    bars = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
             24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
    restart(1'b1, 0, 3);
    run(200);
    hs_low = 0; blank_hi = 0; vs_low = 0; rdy_cnt = 0; clk_bad = 0; lock_cnt = 0;
    fall1 = -1; fall2 = -1;
    for (int i = 2; i < 30; i++) begin
      if (o_hs[i] === 1'b0) hs_low++;
      if (o_blank[i] === 1'b1) blank_hi++;
    end
    for (int i = 2; i < 198; i++) if (o_vs[i] === 1'b0) vs_low++;
    for (int i = 3; i < 200; i++) begin
      if (o_hs[i-1] === 1'b1 && o_hs[i] === 1'b0) begin
        if (fall1 < 0) fall1 = i;
        else if (fall2 < 0) fall2 = i;
      end
    end
    for (int i = 0; i < 200; i++) begin
      if (o_rdy[i] !== 1'b0) rdy_cnt++;
      if (o_clk[i] !== 1'(i)) clk_bad++;
      if (o_lock[i] !== 1'b0) lock_cnt++;
    end
    checks++; if (hs_low != 4) begin errors++; $display("FAIL hs_low_clks: got %0d expected 4", hs_low); end
    checks++; if (fall1 != 22) begin errors++; $display("FAIL hs_first_fall: got %0d expected 22", fall1); end
    checks++; if (fall2 - fall1 != 28) begin errors++; $display("FAIL hs_period: got %0d expected 28", fall2 - fall1); end
    checks++; if (vs_low != 28) begin errors++; $display("FAIL vs_low_clks: got %0d expected 28", vs_low); end
    checks++; if (blank_hi != 16) begin errors++; $display("FAIL blank_hi_clks: got %0d expected 16", blank_hi); end
    checks++; if (rdy_cnt != 0) begin errors++; $display("FAIL pattern_ready: got %0d ready clks expected 0", rdy_cnt); end
    checks++; if (clk_bad != 0) begin errors++; $display("FAIL vga_clk_phase: got %0d bad clks expected 0", clk_bad); end
    checks++; if (lock_cnt != 0) begin errors++; $display("FAIL pattern_locked: got %0d locked clks expected 0", lock_cnt); end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (o_rgb[2+2*i] !== bars[i]) begin errors++; $display("FAIL bar%0d: got %h expected %h", i, o_rgb[2+2*i], bars[i]); end
    end
    checks++; if (o_rgb[20] !== 24'h0) begin errors++; $display("FAIL bar_blank: got %h expected 000000", o_rgb[20]); end
  endtask

  task automatic test_stream();
    int hp, vp, fr;
    logic [23:0] expv;
    restart(1'b0, 0, 0);
    run(400);
    checks++; if (o_lock[1] !== 1'b0) begin errors++; $display("FAIL lock_before: got %b expected 0", o_lock[1]); end
    checks++; if (o_lock[2] !== 1'b1) begin errors++; $display("FAIL lock_at_start: got %b expected 1", o_lock[2]); end
    for (int i = 2; i < 400; i += 2) begin
      hp = ((i - 2) / 2) % 14; vp = ((i - 2) / 28) % 7; fr = (i - 2) / 196;
      expv = (hp < 8 && vp < 4) ? pix(fr, vp * 8 + hp) : 24'h0;
      checks++;
      if (o_rgb[i] !== expv) begin errors++; $display("FAIL stream_px k=%0d: got %h expected %h", i, o_rgb[i], expv); end
    end
    checks++; if (o_uf[399] !== 1'b0) begin errors++; $display("FAIL stream_uf: got %b expected 0", o_uf[399]); end
    checks++; if (o_lock[399] !== 1'b1) begin errors++; $display("FAIL stream_lock: got %b expected 1", o_lock[399]); end
  endtask

  task automatic test_underflow();
    restart(1'b0, 0, 0);
    drop_k = 33;
    run(205);
    clr_underflow = 1'b1;
    step();
    clr_underflow = 1'b0;
    run(4);
    checks++; if (o_rgb[32] !== pix(0, 9)) begin errors++; $display("FAIL uf_prev_px: got %h expected %h", o_rgb[32], pix(0, 9)); end
    checks++; if (o_uf[33] !== 1'b0) begin errors++; $display("FAIL uf_early: got %b expected 0", o_uf[33]); end
    checks++; if (o_rgb[34] !== 24'h0) begin errors++; $display("FAIL uf_black: got %h expected 000000", o_rgb[34]); end
    checks++; if (o_uf[34] !== 1'b1) begin errors++; $display("FAIL uf_set: got %b expected 1", o_uf[34]); end
    checks++; if (o_lock[34] !== 1'b0) begin errors++; $display("FAIL uf_unlock: got %b expected 0", o_lock[34]); end
    checks++; if (o_rgb[36] !== 24'h0) begin errors++; $display("FAIL uf_after_black: got %h expected 000000", o_rgb[36]); end
    checks++; if (o_lock[198] !== 1'b1) begin errors++; $display("FAIL uf_relock: got %b expected 1", o_lock[198]); end
    checks++; if (o_rgb[198] !== pix(1, 0)) begin errors++; $display("FAIL uf_relock_px0: got %h expected %h", o_rgb[198], pix(1, 0)); end
    checks++; if (o_rgb[200] !== pix(1, 1)) begin errors++; $display("FAIL uf_relock_px1: got %h expected %h", o_rgb[200], pix(1, 1)); end
    checks++; if (o_uf[205] !== 1'b1) begin errors++; $display("FAIL uf_sticky: got %b expected 1", o_uf[205]); end
    checks++; if (o_uf[206] !== 1'b0) begin errors++; $display("FAIL uf_clear: got %b expected 0", o_uf[206]); end
  endtask

  task automatic test_premature_sop();
    int rdy_cnt;
    restart(1'b0, 0, 0);
    jump_en = 1'b1;
    run(202);
    rdy_cnt = 0;
    for (int i = 11; i < 197; i++) if (o_rdy[i] !== 1'b0) rdy_cnt++;
    checks++; if (o_rgb[10] !== pix(0, 4)) begin errors++; $display("FAIL sop_px4: got %h expected %h", o_rgb[10], pix(0, 4)); end
    checks++; if (o_rgb[12] !== 24'h0) begin errors++; $display("FAIL sop_px5_black: got %h expected 000000", o_rgb[12]); end
    checks++; if (o_lock[12] !== 1'b0) begin errors++; $display("FAIL sop_unlock: got %b expected 0", o_lock[12]); end
    checks++; if (o_uf[12] !== 1'b0) begin errors++; $display("FAIL sop_no_uf: got %b expected 0", o_uf[12]); end
    checks++; if (rdy_cnt != 0) begin errors++; $display("FAIL sop_held: got %0d ready clks expected 0", rdy_cnt); end
    checks++; if (o_rgb[40] !== 24'h0) begin errors++; $display("FAIL sop_mid_black: got %h expected 000000", o_rgb[40]); end
    checks++; if (o_rgb[198] !== pix(1, 0)) begin errors++; $display("FAIL sop_realign: got %h expected %h", o_rgb[198], pix(1, 0)); end
    checks++; if (o_rgb[200] !== pix(1, 1)) begin errors++; $display("FAIL sop_realign_px1: got %h expected %h", o_rgb[200], pix(1, 1)); end
  endtask

  task automatic test_garbage();
    int acc_cnt;
    restart(1'b0, 0, 20);
    run(202);
    acc_cnt = 0;
    for (int i = 0; i < 12; i++) if (o_acc[i] === 1'b1) acc_cnt++;
    checks++; if (acc_cnt != 12) begin errors++; $display("FAIL garbage_drop: got %0d accepted expected 12", acc_cnt); end
    checks++; if (o_rdy[12] !== 1'b0) begin errors++; $display("FAIL garbage_sop_hold: got %b expected 0", o_rdy[12]); end
    checks++; if (o_rgb[2] !== 24'h0) begin errors++; $display("FAIL garbage_black: got %h expected 000000", o_rgb[2]); end
    checks++; if (o_lock[2] !== 1'b0) begin errors++; $display("FAIL garbage_nolock: got %b expected 0", o_lock[2]); end
    checks++; if (o_lock[198] !== 1'b1) begin errors++; $display("FAIL garbage_lock: got %b expected 1", o_lock[198]); end
    checks++; if (o_rgb[198] !== pix(1, 0)) begin errors++; $display("FAIL garbage_first_px: got %h expected %h", o_rgb[198], pix(1, 0)); end
  endtask

  task automatic test_reset_mid();
    restart(1'b0, 0, 0);
    run(60);
    reset = 1'b1;
    @(negedge clk);
    #1;
    checks++; if ({vga_r, vga_g, vga_b} !== 24'h0) begin errors++; $display("FAIL mid_rst_rgb: got %h expected 000000", {vga_r, vga_g, vga_b}); end
    checks++; if ({vga_blank_n, vga_hs, vga_vs, vga_clk} !== 4'b0110) begin errors++; $display("FAIL mid_rst_pins: got %b expected 0110", {vga_blank_n, vga_hs, vga_vs, vga_clk}); end
    checks++; if ({locked, in_ready} !== 2'b00) begin errors++; $display("FAIL mid_rst_ctrl: got %b expected 00", {locked, in_ready}); end
    @(negedge clk);
    reset = 1'b0;
    k = 0; src_f = 2; src_p = 0;
    run(30);
    checks++; if (o_rgb[2] !== pix(2, 0)) begin errors++; $display("FAIL mid_rst_px0: got %h expected %h", o_rgb[2], pix(2, 0)); end
    checks++; if (o_blank[2] !== 1'b1 || o_lock[2] !== 1'b1) begin errors++; $display("FAIL mid_rst_restart: got %b%b expected 11", o_blank[2], o_lock[2]); end
    checks++; if (o_hs[21] !== 1'b1 || o_hs[22] !== 1'b0) begin errors++; $display("FAIL mid_rst_hs: got %b%b expected 10", o_hs[21], o_hs[22]); end
  endtask

  initial begin
    k = 0; src_on = 1'b0; jump_en = 1'b0; src_f = 0; src_p = 0; drop_k = -1;
    test_reset();
    test_timing();
    test_stream();
    test_underflow();
    test_premature_sop();
    test_garbage();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
